// File: rtl/rectangle_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rectangle_pkg                                                         |
// | Shared types, S-box and round-constant LFSR for the RECTANGLE         |
// | key schedule.                                                         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package rectangle_pkg;

  localparam logic [4:0] RC_INIT = 5'h01;

  typedef enum logic {
    KEY80  = 1'b0,
    KEY128 = 1'b1
  } key_len_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } skey_state_e;

  function automatic logic [3:0] rectangle_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h6;
      4'h1: y = 4'h5;
      4'h2: y = 4'hC;
      4'h3: y = 4'hA;
      4'h4: y = 4'h1;
      4'h5: y = 4'hE;
      4'h6: y = 4'h7;
      4'h7: y = 4'h9;
      4'h8: y = 4'hB;
      4'h9: y = 4'h0;
      4'hA: y = 4'h3;
      4'hB: y = 4'hD;
      4'hC: y = 4'h8;
      4'hD: y = 4'hF;
      4'hE: y = 4'h4;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [4:0] rc_step(input logic [4:0] rc);
    return {rc[3:0], rc[4] ^ rc[2]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rectangle_skey_round.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rectangle_skey_round                                                  |
// | Combinational one-round key-state update for 80- and 128-bit keys.    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module rectangle_skey_round
  import rectangle_pkg::*;
(
  input  logic [127:0] i_state,
  input  key_len_e     i_mode,
  input  logic [4:0]   i_rc,
  output logic [127:0] o_state
);

  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [15:0]  w_h0, w_h1, w_h2, w_h3, w_h4;
  logic [127:0] w_next128, w_next80;

  // Column nibble is {r3,r2,r1,r0}; S-box output bit j lands in row j.
  always_comb begin
    w_w0 = i_state[31:0];
    w_w1 = i_state[63:32];
    w_w2 = i_state[95:64];
    w_w3 = i_state[127:96];
    for (int c = 0; c < 8; c++) begin
      {w_w3[c], w_w2[c], w_w1[c], w_w0[c]} =
        rectangle_sbox({i_state[96+c], i_state[64+c], i_state[32+c], i_state[c]});
    end
  end

  always_comb begin
    w_h0 = i_state[15:0];
    w_h1 = i_state[31:16];
    w_h2 = i_state[47:32];
    w_h3 = i_state[63:48];
    w_h4 = i_state[79:64];
    for (int c = 0; c < 4; c++) begin
      {w_h3[c], w_h2[c], w_h1[c], w_h0[c]} =
        rectangle_sbox({i_state[48+c], i_state[32+c], i_state[16+c], i_state[c]});
    end
  end

  assign w_next128 = {w_w0,
                      {w_w2[15:0], w_w2[31:16]} ^ w_w3,
                      w_w2,
                      {w_w0[23:0], w_w0[31:24]} ^ w_w1 ^ {27'd0, i_rc}};

  assign w_next80 = {48'd0,
                     w_h0,
                     {w_h3[3:0], w_h3[15:4]} ^ w_h4,
                     w_h3,
                     w_h2,
                     {w_h0[7:0], w_h0[15:8]} ^ w_h1 ^ {11'd0, i_rc}};

  assign o_state = (i_mode == KEY128) ? w_next128 : w_next80;

endmodule
`default_nettype wire

// File: rtl/rectangle_skeygen_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rectangle_skeygen_multi                                               |
// | RECTANGLE key schedule: writes NUM_ROUNDS+1 subkeys, one per cycle.   |
// | Optional RECTANGLE_SKEY_FLUSH_EN: flush_mem pulse on start accept.    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module rectangle_skeygen_multi
  import rectangle_pkg::*;
#(
  parameter int NUM_ROUNDS = 25,
  parameter int ADDR_W     = 5
)(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic              key_len,
  input  logic [127:0]      key_in,
  output logic              busy,
  output logic              done,
  output logic              flush_mem,
  output logic              WE_mem,
  output logic [ADDR_W-1:0] WAddr_mem,
  output logic [63:0]       KeyIn_mem
);

  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(NUM_ROUNDS);

  skey_state_e       r_state, w_next_state;
  logic [127:0]      r_key, w_key_next;
  key_len_e          r_mode;
  logic [4:0]        r_rc;
  logic [ADDR_W-1:0] r_cnt;
  logic              w_accept, w_last;
  logic [63:0]       w_subkey;

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_cnt == c_LAST);

  rectangle_skey_round u_round (
    .i_state (r_key),
    .i_mode  (r_mode),
    .i_rc    (r_rc),
    .o_state (w_key_next)
  );

  // 80-bit rows are 16 bits wide, so the low 64 bits are already {r3,r2,r1,r0}.
  assign w_subkey = (r_mode == KEY128) ?
                    {r_key[111:96], r_key[79:64], r_key[47:32], r_key[15:0]} :
                    r_key[63:0];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start)  w_next_state = RUN;
      RUN:     if (w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    WE_mem    = 1'b0;
    WAddr_mem = '0;
    KeyIn_mem = '0;
    case (r_state)
      RUN: begin
        busy      = 1'b1;
        WE_mem    = 1'b1;
        WAddr_mem = r_cnt;
        KeyIn_mem = w_subkey;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

`ifdef RECTANGLE_SKEY_FLUSH_EN
  assign flush_mem = w_accept;
`else
  assign flush_mem = 1'b0;
`endif

  // The state is not advanced past the final subkey, keeping the counter in range.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_key  <= '0;
      r_mode <= KEY80;
      r_rc   <= RC_INIT;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_key  <= key_len ? key_in : {48'd0, key_in[79:0]};
      r_mode <= key_len_e'(key_len);
      r_rc   <= RC_INIT;
      r_cnt  <= '0;
    end else if ((r_state == RUN) && !w_last) begin
      r_key  <= w_key_next;
      r_rc   <= rc_step(r_rc);
      r_cnt  <= r_cnt + ADDR_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rectangle_skeygen_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rectangle_skeygen_multi                                            |
// | Scoreboard bench: expected subkey writes queued at start, popped by   |
// | a monitor on each write. Rev 1.0                                      |
// +----------------------------------------------------------------------+
module tb_rectangle_skeygen_multi;

  localparam int NR   = 25;
  localparam int NR31 = 31;
  localparam int AW   = 5;
`ifdef RECTANGLE_SKEY_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          start = 1'b0;
  logic          start31 = 1'b0;
  logic          key_len = 1'b0;
  logic [127:0]  key_in = '0;

  logic          busy_a, done_a, flush_a, we_a;
  logic [AW-1:0] waddr_a;
  logic [63:0]   wdata_a;
  logic          busy_b, done_b, flush_b, we_b;
  logic [AW-1:0] waddr_b;
  logic [63:0]   wdata_b;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [63:0]   data;
  } wr_t;

  wr_t q_a[$];
  wr_t q_b[$];
  int  errors = 0;
  int  checks = 0;
  int  wr_a = 0;
  int  wr_b = 0;
  bit  idle_a = 1'b1;
  bit  idle_b = 1'b1;

  always #5 Clk = ~Clk;

  rectangle_skeygen_multi #(.NUM_ROUNDS(NR), .ADDR_W(AW)) u_dut (
    .Clk(Clk), .Rst(Rst), .start(start), .key_len(key_len), .key_in(key_in),
    .busy(busy_a), .done(done_a), .flush_mem(flush_a), .WE_mem(we_a),
    .WAddr_mem(waddr_a), .KeyIn_mem(wdata_a)
  );

  rectangle_skeygen_multi #(.NUM_ROUNDS(NR31), .ADDR_W(AW)) u_dut31 (
    .Clk(Clk), .Rst(Rst), .start(start31), .key_len(key_len), .key_in(key_in),
    .busy(busy_b), .done(done_b), .flush_mem(flush_b), .WE_mem(we_b),
    .WAddr_mem(waddr_b), .KeyIn_mem(wdata_b)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] sb(input logic [3:0] x);
    logic [63:0] t;
    t = 64'h65CA1E79B03D8F42;
    return t[63-4*int'(x) -: 4];
  endfunction

  function automatic logic [15:0] rot16(input logic [15:0] x, input int n);
    return (x << n) | (x >> (16 - n));
  endfunction

  // Reference schedule built row-by-row from the algorithm description.
  task automatic push_model(input bit k128, input logic [127:0] key, input int nr, input bit to_b);
    logic [31:0] r[5];
    logic [31:0] t[5];
    logic [4:0]  rc;
    logic [3:0]  s;
    wr_t         e;
    int          nc;
    nc = k128 ? 8 : 4;
    for (int i = 0; i < 5; i++) r[i] = '0;
    for (int i = 0; i < 5; i++) begin
      if (k128 && i < 4) r[i] = key[32*i +: 32];
      else if (!k128)    r[i] = {16'd0, key[16*i +: 16]};
    end
    rc = 5'h01;
    for (int k = 0; k <= nr; k++) begin
      e.addr = AW'(k);
      e.data = {r[3][15:0], r[2][15:0], r[1][15:0], r[0][15:0]};
      if (to_b) q_b.push_back(e);
      else      q_a.push_back(e);
      for (int c = 0; c < nc; c++) begin
        s = sb({r[3][c], r[2][c], r[1][c], r[0][c]});
        for (int j = 0; j < 4; j++) r[j][c] = s[j];
      end
      for (int i = 0; i < 5; i++) t[i] = '0;
      if (k128) begin
        t[0] = ((r[0] << 8) | (r[0] >> 24)) ^ r[1] ^ {27'd0, rc};
        t[1] = r[2];
        t[2] = ((r[2] << 16) | (r[2] >> 16)) ^ r[3];
        t[3] = r[0];
      end else begin
        t[0] = {16'd0, rot16(r[0][15:0], 8) ^ r[1][15:0] ^ {11'd0, rc}};
        t[1] = r[2];
        t[2] = r[3];
        t[3] = {16'd0, rot16(r[3][15:0], 12) ^ r[4][15:0]};
        t[4] = r[0];
      end
      for (int i = 0; i < 5; i++) r[i] = t[i];
      rc = {rc[3:0], rc[4] ^ rc[2]};
    end
  endtask

  // Replace the first two expected entries with hand-derived constants.
  task automatic set_hand(input logic [63:0] k0, input logic [63:0] k1);
    wr_t e;
    e.addr = AW'(0); e.data = k0; q_a[0] = e;
    e.addr = AW'(1); e.data = k1; q_a[1] = e;
  endtask

  always @(negedge Clk) begin
    wr_t e;
    if (we_a) begin
      wr_a++;
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL write_a unexpected addr=%0d data=%h", waddr_a, wdata_a);
      end else begin
        e = q_a.pop_front();
        chk("write_a", {waddr_a, wdata_a}, {e.addr, e.data});
      end
    end
    if (we_b) begin
      wr_b++;
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL write_b unexpected addr=%0d data=%h", waddr_b, wdata_b);
      end else begin
        e = q_b.pop_front();
        chk("write_b", {waddr_b, wdata_b}, {e.addr, e.data});
      end
    end
    chk("flush_a", 64'(flush_a), 64'(FLUSH_ON && start && idle_a));
    chk("flush_b", 64'(flush_b), 64'(FLUSH_ON && start31 && idle_b));
  end

  task automatic run(input bit to_b, input bit k128, input logic [127:0] key,
                     input int pulse_at, input int rst_at);
    int nr;
    nr = to_b ? NR31 : NR;
    if (to_b) wr_b = 0; else wr_a = 0;
    @(posedge Clk); #1;
    key_len = k128;
    key_in  = key;
    if (to_b) start31 = 1'b1; else start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0; start31 = 1'b0;
    if (to_b) idle_b = 1'b0; else idle_a = 1'b0;
    key_in  = ~key;
    key_len = ~k128;
    for (int c = 1; c <= nr + 3; c++) begin
      @(negedge Clk);
      if (rst_at != 0 && c == rst_at) begin
        #1 Rst = 1'b1;
        #1;
        chk("rst_we", 64'(we_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_partial_writes", 64'(wr_a), 64'(rst_at));
        q_a.delete();
        idle_a = 1'b1;
        @(negedge Clk);
        chk("rst_hold_we", 64'(we_a), 64'd0);
        #2 Rst = 1'b0;
        return;
      end
      chk(to_b ? "busy_b" : "busy_a", 64'(to_b ? busy_b : busy_a), 64'(c <= nr + 1));
      chk(to_b ? "done_b" : "done_a", 64'(to_b ? done_b : done_a), 64'(c == nr + 2));
      if (pulse_at != 0 && c == pulse_at) begin
        #2 start = 1'b1; key_in = {4{32'hA5A5_5A5A}}; key_len = 1'b1;
      end else if (pulse_at != 0 && c == pulse_at + 1) begin
        #2 start = 1'b0;
      end
    end
    if (to_b) idle_b = 1'b1; else idle_a = 1'b1;
    chk(to_b ? "write_count_b" : "write_count_a", 64'(to_b ? wr_b : wr_a), 64'(nr + 1));
    chk(to_b ? "queue_left_b" : "queue_left_a", 64'(to_b ? q_b.size() : q_a.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge Clk);
    chk("reset_busy", 64'(busy_a), 64'd0);
    chk("reset_done", 64'(done_a), 64'd0);
    chk("reset_we", 64'(we_a), 64'd0);
    chk("reset_waddr", 64'(waddr_a), 64'd0);
    chk("reset_wdata", wdata_a, 64'd0);
    chk("reset_we_b", 64'(we_b), 64'd0);
    #2 Rst = 1'b0;
    @(negedge Clk);
    chk("post_reset_idle", {busy_a, done_a, we_a, waddr_a, wdata_a}, '0);

    // 128-bit zero key: K1 = 00FF/00FE in rows 1/0
    push_model(1'b1, '0, NR, 1'b0);
    set_hand(64'd0, 64'h0000_0000_00FF_00FE);
    run(1'b0, 1'b1, '0, 0, 0);

    // 80-bit zero key, then with the ignored upper bits all ones
    push_model(1'b0, '0, NR, 1'b0);
    set_hand(64'd0, 64'h0000_0000_000F_000E);
    run(1'b0, 1'b0, '0, 0, 0);
    push_model(1'b0, '0, NR, 1'b0);
    set_hand(64'd0, 64'h0000_0000_000F_000E);
    run(1'b0, 1'b0, {48'hFFFF_FFFF_FFFF, 80'd0}, 0, 0);

    // Non-trivial keys in both modes
    push_model(1'b1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, NR, 1'b0);
    run(1'b0, 1'b1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, 0);
    push_model(1'b0, 128'h0000_0000_0000_1357_9BDF_0246_8ACE_F00D, NR, 1'b0);
    run(1'b0, 1'b0, 128'h0000_0000_0000_1357_9BDF_0246_8ACE_F00D, 0, 0);

    // Second start mid-run is ignored
    push_model(1'b1, 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D, NR, 1'b0);
    run(1'b0, 1'b1, 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D, 5, 0);

    // Reset mid-run, then a full rewrite
    push_model(1'b1, 128'h1111_2222_3333_4444_5555_6666_7777_8888, NR, 1'b0);
    run(1'b0, 1'b1, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 0, 10);
    @(negedge Clk);
    chk("after_rst_busy", 64'(busy_a), 64'd0);
    push_model(1'b1, 128'h1111_2222_3333_4444_5555_6666_7777_8888, NR, 1'b0);
    run(1'b0, 1'b1, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 0, 0);

    // 31-round instance exercises the full LFSR period range
    push_model(1'b1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, NR31, 1'b1);
    run(1'b1, 1'b1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 0, 0);
    push_model(1'b0, 128'h0000_0000_0000_0000_0000_0000_0000_0000, NR31, 1'b1);
    run(1'b1, 1'b0, '0, 0, 0);

    repeat (3) @(negedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
